// File: rtl/ysyx_25040129_csr_seq_pkg.sv
// ysyx_25040129_csr_seq_pkg: op codes, CSR addresses and helpers shared by the CSR sequencer.
`default_nettype none

package ysyx_25040129_csr_seq_pkg;

  localparam int CSR_DIG = 12;

  typedef enum logic [2:0] {
    OP_CSRRW  = 3'd0,
    OP_CSRRS  = 3'd1,
    OP_CSRRC  = 3'd2,
    OP_ECALL  = 3'd3,
    OP_CSRRWI = 3'd4,
    OP_CSRRSI = 3'd5,
    OP_CSRRCI = 3'd6,
    OP_MRET   = 3'd7
  } csr_op_e;

  localparam logic [CSR_DIG-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_DIG-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_DIG-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_DIG-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_DIG-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [CSR_DIG-1:0] CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  function automatic logic is_read_only(input logic [CSR_DIG-1:0] addr);
    return (addr == CSR_MVENDORID) || (addr == CSR_MARCHID);
  endfunction

  // Immediate forms carry zimm in the rs1 field; ECALL/MRET have no operand.
  function automatic logic is_imm_op(input logic [2:0] op);
    return (op == OP_CSRRWI) || (op == OP_CSRRSI) || (op == OP_CSRRCI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25040129_csr_alu.sv
// ysyx_25040129_csr_alu: new CSR value and write-enable for one CSR read-modify-write.
`default_nettype none

module ysyx_25040129_csr_alu
  import ysyx_25040129_csr_seq_pkg::*;
(
  input  logic [2:0]         op,
  input  logic [CSR_DIG-1:0] addr,
  input  logic [4:0]         rs1_idx,
  input  logic [31:0]        old_val,
  input  logic [31:0]        operand,
  output logic [31:0]        new_val,
  output logic               write_en
);

  always_comb begin
    new_val  = old_val;
    write_en = 1'b0;
    case (op)
      OP_CSRRW, OP_CSRRWI: begin
        new_val  = operand;
        write_en = 1'b1;
      end
      // Set/clear with x0 (or zimm 0) is a pure read.
      OP_CSRRS, OP_CSRRSI: begin
        new_val  = old_val | operand;
        write_en = (rs1_idx != 5'd0);
      end
      OP_CSRRC, OP_CSRRCI: begin
        new_val  = old_val & ~operand;
        write_en = (rs1_idx != 5'd0);
      end
      default: begin
        new_val  = old_val;
        write_en = 1'b0;
      end
    endcase
    if (is_read_only(addr)) write_en = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040129_csr_seq.sv
// ysyx_25040129_csr_seq: one-at-a-time CSR instruction sequencer driving a single-port CSR file.
`default_nettype none

module ysyx_25040129_csr_seq
  import ysyx_25040129_csr_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [CSR_DIG-1:0] in_csr_addr,
  input  logic [4:0]         in_rs1_idx,
  input  logic [31:0]        in_rs1_data,
  input  logic [31:0]        in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_rd_data,
  output logic               out_redirect,
  output logic [31:0]        out_redirect_pc,
  output logic [CSR_DIG-1:0] csr_read_addr,
  input  logic [31:0]        csr_out,
  output logic               csr_write,
  output logic [CSR_DIG-1:0] csr_write_addr,
  output logic [31:0]        csr_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_EPC   = 3'd2,
    S_CAUSE = 3'd3,
    S_VEC   = 3'd4,
    S_RET   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e             state;
  logic [2:0]         op_q;
  logic [CSR_DIG-1:0] addr_q;
  logic [4:0]         rs1_idx_q;
  logic [31:0]        operand_q;
  logic [31:0]        pc_q;

  logic [31:0]        alu_new;
  logic               alu_we;

  ysyx_25040129_csr_alu u_alu (
    .op       (op_q),
    .addr     (addr_q),
    .rs1_idx  (rs1_idx_q),
    .old_val  (csr_out),
    .operand  (operand_q),
    .new_val  (alu_new),
    .write_en (alu_we)
  );

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  // CSR port is driven straight from the state so the old value read in EXEC
  // feeds the write data of the same cycle.
  always_comb begin
    csr_read_addr  = '0;
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_data       = '0;
    case (state)
      S_EXEC: begin
        csr_read_addr = addr_q;
        if (alu_we) begin
          csr_write      = 1'b1;
          csr_write_addr = addr_q;
          csr_data       = alu_new;
        end
      end
      S_EPC: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_MEPC;
        csr_data       = pc_q;
      end
      S_CAUSE: begin
        csr_write      = 1'b1;
        csr_write_addr = CSR_MCAUSE;
        csr_data       = CAUSE_ECALL_M;
      end
      S_VEC:   csr_read_addr = CSR_MTVEC;
      S_RET:   csr_read_addr = CSR_MEPC;
      default: csr_read_addr = '0;
    endcase
    if (rst) csr_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      op_q            <= 3'd0;
      addr_q          <= '0;
      rs1_idx_q       <= 5'd0;
      operand_q       <= 32'd0;
      pc_q            <= 32'd0;
      out_rd_data     <= 32'd0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q            <= in_op;
            addr_q          <= in_csr_addr;
            rs1_idx_q       <= in_rs1_idx;
            operand_q       <= is_imm_op(in_op) ? {27'd0, in_rs1_idx} : in_rs1_data;
            pc_q            <= in_pc;
            out_rd_data     <= 32'd0;
            out_redirect    <= 1'b0;
            out_redirect_pc <= 32'd0;
            case (in_op)
              OP_CSRRW, OP_CSRRS, OP_CSRRC,
              OP_CSRRWI, OP_CSRRSI, OP_CSRRCI: state <= S_EXEC;
              OP_ECALL:                        state <= S_EPC;
              OP_MRET:                         state <= S_RET;
              default:                         state <= S_DONE;
            endcase
          end
        end
        S_EXEC: begin
          out_rd_data <= csr_out;
          state       <= S_DONE;
        end
        S_EPC:   state <= S_CAUSE;
        S_CAUSE: state <= S_VEC;
        S_VEC, S_RET: begin
          out_redirect_pc <= csr_out;
          out_redirect    <= 1'b1;
          state           <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040129_csr_seq.sv
// tb_ysyx_25040129_csr_seq: directed and random CSR instructions checked against a CSR-level model.
`default_nettype none

module tb_ysyx_25040129_csr_seq;

  localparam logic [31:0] VENDOR = 32'h79737978;
  localparam logic [31:0] ARCH   = 32'h0000_0019;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [11:0] in_csr_addr = 12'd0;
  logic [4:0]  in_rs1_idx = 5'd0;
  logic [31:0] in_rs1_data = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_out;
  logic        csr_write;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_25040129_csr_seq dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_csr_addr     (in_csr_addr),
    .in_rs1_idx      (in_rs1_idx),
    .in_rs1_data     (in_rs1_data),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rd_data     (out_rd_data),
    .out_redirect    (out_redirect),
    .out_redirect_pc (out_redirect_pc),
    .csr_read_addr   (csr_read_addr),
    .csr_out         (csr_out),
    .csr_write       (csr_write),
    .csr_write_addr  (csr_write_addr),
    .csr_data        (csr_data)
  );

  always #5 clk = ~clk;

  // CSR file: combinational read, write lands on the closing edge, reset with the block.
  logic [31:0] cfile [4096];
  assign csr_out = cfile[csr_read_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) cfile[i] <= 32'd0;
      cfile[12'hF11] <= VENDOR;
      cfile[12'hF12] <= ARCH;
    end else if (csr_write) begin
      cfile[csr_write_addr] <= csr_data;
    end
  end

  logic [43:0] wr_log [$];
  always @(negedge clk) if (!rst && csr_write) wr_log.push_back({csr_write_addr, csr_data});

  // Architectural reference state and per-instruction expectations.
  logic [31:0] ref_csr [4096];
  logic [43:0] exp_q [$];
  logic [31:0] exp_rd, exp_rpc;
  logic        exp_redir;
  int          exp_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 4096; i++) ref_csr[i] = 32'd0;
    ref_csr[12'hF11] = VENDOR;
    ref_csr[12'hF12] = ARCH;
  endtask

  task automatic model(input logic [2:0] op, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] d, input logic [31:0] pc);
    logic [31:0] opnd, old, nv;
    logic wr;
    exp_q.delete();
    exp_rd = 0; exp_rpc = 0; exp_redir = 0; exp_lat = 2;
    if (op == 3'd3) begin
      exp_q.push_back({12'h341, pc});
      exp_q.push_back({12'h342, 32'd11});
      ref_csr[12'h341] = pc;
      ref_csr[12'h342] = 32'd11;
      exp_redir = 1; exp_rpc = ref_csr[12'h305]; exp_lat = 4;
    end else if (op == 3'd7) begin
      exp_redir = 1; exp_rpc = ref_csr[12'h341];
    end else begin
      old  = ref_csr[a];
      opnd = (op >= 3'd4) ? {27'd0, idx} : d;
      nv   = old; wr = 0;
      if (op == 3'd0 || op == 3'd4) begin nv = opnd; wr = 1; end
      else if (op == 3'd1 || op == 3'd5) begin nv = old | opnd; wr = (idx != 0); end
      else begin nv = old & ~opnd; wr = (idx != 0); end
      if (a == 12'hF11 || a == 12'hF12) wr = 0;
      if (wr) begin ref_csr[a] = nv; exp_q.push_back({a, nv}); end
      exp_rd = old;
    end
  endtask

  task automatic run_instr(input string tag, input logic [2:0] op, input logic [11:0] a,
                           input logic [4:0] idx, input logic [31:0] d, input logic [31:0] pc,
                           input int hold);
    int w, lat;
    model(op, a, idx, d, pc);
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk({tag, ".in_ready"}, in_ready, 1);
    wr_log.delete();
    in_op = op; in_csr_addr = a; in_rs1_idx = idx; in_rs1_data = d; in_pc = pc;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    in_rs1_data = $urandom; in_pc = $urandom; in_csr_addr = 12'(($urandom));
    in_rs1_idx = 5'($urandom); in_op = 3'($urandom);
    chk({tag, ".busy"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".rd"}, out_rd_data, exp_rd);
    chk({tag, ".redir"}, out_redirect, exp_redir);
    chk({tag, ".rpc"}, out_redirect_pc, exp_rpc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_rd"}, out_rd_data, exp_rd);
      chk({tag, ".hold_rpc"}, out_redirect_pc, exp_rpc);
      chk({tag, ".hold_ready"}, in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, ".idle_valid"}, out_valid, 0);
    chk({tag, ".nwrites"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      chk({tag, ".waddr"}, {20'd0, wr_log[i][43:32]}, {20'd0, exp_q[i][43:32]});
      chk({tag, ".wdata"}, wr_log[i][31:0], exp_q[i][31:0]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".rd"}, out_rd_data, 0);
    chk({tag, ".redir"}, out_redirect, 0);
    chk({tag, ".rpc"}, out_redirect_pc, 0);
    chk({tag, ".write"}, csr_write, 0);
    chk({tag, ".raddr"}, {20'd0, csr_read_addr}, 0);
    chk({tag, ".waddr"}, {20'd0, csr_write_addr}, 0);
    chk({tag, ".wdata"}, csr_data, 0);
  endtask

  localparam logic [11:0] ADDRS [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h340};

  initial begin
    logic [2:0]  op;
    logic [4:0]  idx;
    ref_reset();
    repeat (3) @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("init.in_ready", in_ready, 1);
    chk_zero("init");

    run_instr("rw_mtvec1", 3'd0, 12'h305, 5'd3, 32'h80000100, 32'h0, 0);
    run_instr("rw_mtvec2", 3'd0, 12'h305, 5'd3, 32'h80000200, 32'h0, 1);
    run_instr("set_mst",   3'd0, 12'h300, 5'd4, 32'h00001800, 32'h0, 0);
    run_instr("rs_x0",     3'd1, 12'h300, 5'd0, 32'hFFFFFFFF, 32'h0, 0);
    run_instr("set_mst2",  3'd0, 12'h300, 5'd4, 32'h00001808, 32'h0, 0);
    run_instr("rcci",      3'd6, 12'h300, 5'd8, 32'hFFFFFFFF, 32'h0, 0);
    run_instr("ecall",     3'd3, 12'h000, 5'd0, 32'h0, 32'h80000010, 2);
    run_instr("set_mepc",  3'd0, 12'h341, 5'd1, 32'h80000014, 32'h0, 0);
    run_instr("mret",      3'd7, 12'h000, 5'd0, 32'h0, 32'h80000030, 0);
    run_instr("rw_vendor", 3'd0, 12'hF11, 5'd2, 32'h0, 32'h0, 5);

    for (int k = 0; k < 60; k++) begin
      op  = 3'($urandom_range(0, 7));
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (op == 3'd4 && idx == 5'd0) idx = 5'd1;
      run_instr("rand", op, ADDRS[$urandom_range(0, 6)], idx, $urandom, $urandom,
                int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an ECALL, while mcause is being written.
    while (!in_ready) @(negedge clk);
    in_op = 3'd3; in_pc = 32'h80000020; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("mid.cause_write", csr_write, 1);
    chk("mid.cause_addr", {20'd0, csr_write_addr}, 32'h342);
    rst = 1;
    @(negedge clk);
    chk("mid.rst_ready", in_ready, 0);
    chk_zero("mid.rst");
    rst = 0;
    ref_reset();
    wr_log.delete();
    #1;
    chk("mid.idle_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("mid.no_writes", wr_log.size(), 0);
    chk("mid.out_valid", out_valid, 0);
    run_instr("post_mcause", 3'd1, 12'h342, 5'd0, 32'h0, 32'h0, 0);
    run_instr("post_mepc",   3'd1, 12'h341, 5'd0, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
